// File: rtl/cla_pkg.sv
// Shared constants for the carry-look-ahead adder: group size and default width.
package cla_pkg;

    localparam int CLA_GROUP   = 4;
    localparam int ADDER_WIDTH = 4;

endpackage

// File: rtl/cla_block4.sv
// 4-bit carry-look-ahead block: two-level carries inside the group plus group generate/propagate.
module cla_block4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic [2:0] c,
    output logic       cout,
    output logic       gg,
    output logic       gp
);

    // Every carry is a flat sum of products of p/g/cin; no carry feeds another.
    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

endmodule

// File: rtl/cla_adder.sv
// Two-stage registered unsigned adder: operand registers, CLA network, sum/carry registers.
module cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int NG = WIDTH / CLA_GROUP;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] s_next;
    logic [NG:0]      gc;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    blk_cout;
    logic             unused_blk_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            s    <= '0;
            cout <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            s    <= s_next;
            cout <= gc[NG];
        end
    end

    assign p = a_q ^ b_q;
    assign g = a_q & b_q;

    // Second-level look-ahead: each group carry is an OR of GG terms gated by the
    // GPs of all intervening groups, so no carry passes from one group to the next.
    always_comb begin
        logic term;
        gc    = '0;
        gc[0] = 1'b0;
        for (int k = 1; k <= NG; k++) begin
            for (int j = 0; j < k; j++) begin
                term = gg[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & gp[m];
                end
                gc[k] = gc[k] | term;
            end
        end
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_block4 u_blk (
            .p    (p[gi*CLA_GROUP +: CLA_GROUP]),
            .g    (g[gi*CLA_GROUP +: CLA_GROUP]),
            .cin  (gc[gi]),
            .c    (c[gi*CLA_GROUP+1 +: 3]),
            .cout (blk_cout[gi]),
            .gg   (gg[gi]),
            .gp   (gp[gi])
        );
        assign c[gi*CLA_GROUP] = gc[gi];
    end

    // Block carry-outs duplicate the group carries already formed by the look-ahead.
    assign unused_blk_cout = ^blk_cout;

    assign s_next = p ^ c;

endmodule

// File: tb/tb_cla_adder.sv
// Directed and sweep bench for cla_adder at WIDTH=4 and WIDTH=8 with an expected-result queue.
module tb_cla_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a4, b4, s4;
    logic       co4;
    logic [7:0] a8, b8, s8;
    logic       co8;

    logic [4:0] exp4_q[$];
    logic [8:0] exp8_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    cla_adder dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .b     (b4),
        .s     (s4),
        .cout  (co4)
    );

    cla_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .s     (s8),
        .cout  (co8)
    );

    // clock block
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: apply one operand pair per edge; e4/e8 are the expected {cout,s} for it.
    // Outputs seen after an edge belong to the operands applied one step earlier.
    task automatic cycle(input string tag, input logic [3:0] x4, input logic [3:0] y4,
                         input logic [7:0] x8, input logic [7:0] y8, input logic rst,
                         input logic [4:0] e4, input logic [8:0] e8);
        a4    = x4;
        b4    = y4;
        a8    = x8;
        b8    = y8;
        rst_n = rst;
        @(posedge clk);
        #1;
        if (!rst) begin
            check({tag, "_w4"}, {4'b0, co4, s4}, 9'h000);
            check({tag, "_w8"}, {co8, s8}, 9'h000);
            exp4_q.delete();
            exp8_q.delete();
            exp4_q.push_back(5'h00);
            exp8_q.push_back(9'h000);
        end else begin
            if (exp4_q.size() > 0) check({tag, "_w4"}, {4'b0, co4, s4}, {4'b0, exp4_q.pop_front()});
            if (exp8_q.size() > 0) check({tag, "_w8"}, {co8, s8}, exp8_q.pop_front());
            exp4_q.push_back(e4);
            exp8_q.push_back(e8);
        end
    endtask

    initial begin
        logic [3:0] x4, y4;
        logic [7:0] x8, y8;
        logic [4:0] r4;
        logic [8:0] r8;

        // reset held for two edges with live operands
        cycle("rst0", 4'd5, 4'd7, 8'd5, 8'd7, 1'b0, 5'h0C, 9'h00C);
        cycle("rst1", 4'd5, 4'd7, 8'd5, 8'd7, 1'b0, 5'h0C, 9'h00C);
        // first edge after release still shows the flushed pipeline
        cycle("rel0", 4'd5, 4'd7, 8'd5, 8'd7, 1'b1, 5'h0C, 9'h00C);
        cycle("hold1", 4'd5, 4'd7, 8'd5, 8'd7, 1'b1, 5'h0C, 9'h00C);
        cycle("hold2", 4'd5, 4'd7, 8'd5, 8'd7, 1'b1, 5'h0C, 9'h00C);

        // carry-chain boundaries
        cycle("f_p_1", 4'd15, 4'd1, 8'd255, 8'd1, 1'b1, 5'h10, 9'h100);
        cycle("f_p_f", 4'd15, 4'd15, 8'd255, 8'd255, 1'b1, 5'h1E, 9'h1FE);
        cycle("8_p_8", 4'd8, 4'd8, 8'd128, 8'd128, 1'b1, 5'h10, 9'h100);
        cycle("0_p_0", 4'd0, 4'd0, 8'd0, 8'd0, 1'b1, 5'h00, 9'h000);

        // back-to-back pipelining
        cycle("pipe0", 4'd3, 4'd4, 8'd200, 8'd100, 1'b1, 5'h07, 9'h12C);
        cycle("pipe1", 4'd9, 4'd9, 8'd17, 8'd34, 1'b1, 5'h12, 9'h033);
        cycle("pipe2", 4'd15, 4'd0, 8'd127, 8'd1, 1'b1, 5'h0F, 9'h080);
        cycle("group", 4'd6, 4'd10, 8'd15, 8'd1, 1'b1, 5'h10, 9'h010);
        cycle("gprop", 4'd1, 4'd2, 8'd240, 8'd16, 1'b1, 5'h03, 9'h100);

        // reset mid-stream: the in-flight 12+12 result must never appear
        cycle("mid0", 4'd12, 4'd12, 8'd250, 8'd10, 1'b1, 5'h18, 9'h104);
        cycle("midrst", 4'd12, 4'd12, 8'd250, 8'd10, 1'b0, 5'h18, 9'h104);
        cycle("post0", 4'd0, 4'd0, 8'd0, 8'd0, 1'b1, 5'h00, 9'h000);
        cycle("post1", 4'd0, 4'd0, 8'd0, 8'd0, 1'b1, 5'h00, 9'h000);

        // full 4-bit sweep alongside a random 8-bit stream
        for (int i = 0; i < 256; i++) begin
            x4 = 4'(i >> 4);
            y4 = 4'(i);
            x8 = 8'($urandom_range(0, 255));
            y8 = 8'($urandom_range(0, 255));
            r4 = {1'b0, x4} + {1'b0, y4};
            r8 = {1'b0, x8} + {1'b0, y8};
            cycle("sweep", x4, y4, x8, y8, 1'b1, r4, r8);
        end

        cycle("drain0", 4'd0, 4'd0, 8'd0, 8'd0, 1'b1, 5'h00, 9'h000);
        cycle("drain1", 4'd0, 4'd0, 8'd0, 8'd0, 1'b1, 5'h00, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
